mux_9to1: RTL and testbench
===========================

Name: mux_9to1

Overview:
Nine-input, one-hot-free selector for the ALU result path. It picks one of nine data inputs (i0..i8) by a binary select code and drives it to a registered output. The block sits between the ALU function units and the result register/flags logic. It also flags illegal select codes.

Parameters:
WIDTH, 1, bit width of each data input and of mux_out (legal range 1..64)
INVALID_VALUE, 0, value driven on mux_out when select is out of range (9..15); truncated or zero-extended to WIDTH

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
select  input  4  binary select code; 0..8 legal, 9..15 illegal
i0  input  WIDTH  data input 0
i1  input  WIDTH  data input 1
i2  input  WIDTH  data input 2
i3  input  WIDTH  data input 3
i4  input  WIDTH  data input 4
i5  input  WIDTH  data input 5
i6  input  WIDTH  data input 6
i7  input  WIDTH  data input 7
i8  input  WIDTH  data input 8
mux_out  output  WIDTH  registered selected data
sel_invalid  output  1  registered flag, 1 when the sampled select was 9..15

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-low (rst_n); release is synchronised by the system, not by this block.
- While rst_n = 0: mux_out = 0 and sel_invalid = 0 immediately, regardless of clk.
- On each rising clk edge with rst_n = 1:
  - Sample select and all nine inputs.
  - If select = k for k in 0..8: mux_out <= ik and sel_invalid <= 0.
  - If select is in 9..15: mux_out <= INVALID_VALUE[WIDTH-1:0] and sel_invalid <= 1.
- Latency is exactly 1 clock from select/data change to mux_out. There is no combinational path from the inputs to the outputs.
- Select is 4 bits wide so that i8 is reachable.
  - A 3-bit driver connected to select is zero-extended by the instantiating context.
  - Codes 8 and 9 from such a driver wrap to 0 and 1. That is a caller issue; this block does not compensate.
- Data inputs are treated as opaque bit vectors. There is no arithmetic and no sign handling.
- X or Z on select: the output is not defined. The bench must not drive X after reset.
- Asserting reset mid-operation clears both outputs asynchronously. The first valid output appears on the first rising edge after rst_n returns to 1.
- If select and data change on the same edge, the values present before the edge are captured (standard flop sampling).
- The block has no handshake and no enable. It updates every cycle.

Test Plan:
- Reset: hold rst_n = 0 with inputs active, toggling clk -> mux_out = 0 and sel_invalid = 0 throughout. Assert rst_n mid-cycle (no edge) -> outputs go to 0 immediately.
- Walk select with WIDTH = 1, i0 = 1, all others 0: select 0 -> mux_out = 1 after one edge; select 1..8 -> mux_out = 0, sel_invalid = 0; each change visible one clock later, not before.
- Invalid codes with i0 = 1: select 9 and 15 -> mux_out = 0 (INVALID_VALUE), sel_invalid = 1. Return to select 2 with i2 = 1 -> mux_out = 1, sel_invalid = 0 on the next edge.
- Distinct data with WIDTH = 8, ik = 8'h10 + k: select k for k = 0..8 -> mux_out = 8'h10..8'h18 respectively, with 1-cycle latency.
- Data change under fixed select: select = 5, i5 changes 8'hAA -> 8'h55 between edges -> mux_out follows on the next edge only. Changing i4 has no effect.
- Parameter check with WIDTH = 4, INVALID_VALUE = 4'hF: select 12 -> mux_out = 4'hF, sel_invalid = 1.

Source files
------------

// File: rtl/mux_9to1.sv
// Nine-way registered selector for the ALU result path; flags select codes 9..15.
// Latency: 1 clk from select/data to mux_out; no handshake, updates every cycle.
module mux_9to1 #(
  parameter int          WIDTH         = 1,
  parameter logic [63:0] INVALID_VALUE = 64'd0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       select,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic [WIDTH-1:0] i4,
  input  logic [WIDTH-1:0] i5,
  input  logic [WIDTH-1:0] i6,
  input  logic [WIDTH-1:0] i7,
  input  logic [WIDTH-1:0] i8,
  output logic [WIDTH-1:0] mux_out,
  output logic             sel_invalid
);

  logic [WIDTH-1:0] w_next;
  logic             w_invalid;
  logic [WIDTH-1:0] r_out;
  logic             r_invalid;

  always_comb begin
    w_next    = INVALID_VALUE[WIDTH-1:0];
    w_invalid = 1'b0;
    case (select)
      4'd0:    w_next = i0;
      4'd1:    w_next = i1;
      4'd2:    w_next = i2;
      4'd3:    w_next = i3;
      4'd4:    w_next = i4;
      4'd5:    w_next = i5;
      4'd6:    w_next = i6;
      4'd7:    w_next = i7;
      4'd8:    w_next = i8;
      // Codes 9..15 keep the default payload and raise the flag.
      default: w_invalid = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out     <= '0;
      r_invalid <= 1'b0;
    end else begin
      r_out     <= w_next;
      r_invalid <= w_invalid;
    end
  end

  assign mux_out     = r_out;
  assign sel_invalid = r_invalid;

endmodule

// File: tb/tb_mux_9to1.sv
// Directed bench for mux_9to1: three instances (WIDTH 1, 8, and 4 with INVALID_VALUE 4'hF).
module tb_mux_9to1;

  logic       clk;
  logic       rst_n;
  logic [3:0] select;

  logic [0:0] d1 [0:8];
  logic [7:0] d8 [0:8];
  logic [3:0] d4 [0:8];

  logic [0:0] o1;
  logic [7:0] o8;
  logic [3:0] o4;
  logic       v1, v8, v4;

  int n_checks = 0;
  int n_errors = 0;

  mux_9to1 #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .select(select),
    .i0(d1[0]), .i1(d1[1]), .i2(d1[2]), .i3(d1[3]), .i4(d1[4]),
    .i5(d1[5]), .i6(d1[6]), .i7(d1[7]), .i8(d1[8]),
    .mux_out(o1), .sel_invalid(v1)
  );

  mux_9to1 #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .select(select),
    .i0(d8[0]), .i1(d8[1]), .i2(d8[2]), .i3(d8[3]), .i4(d8[4]),
    .i5(d8[5]), .i6(d8[6]), .i7(d8[7]), .i8(d8[8]),
    .mux_out(o8), .sel_invalid(v8)
  );

  mux_9to1 #(.WIDTH(4), .INVALID_VALUE(64'hF)) u_w4 (
    .clk(clk), .rst_n(rst_n), .select(select),
    .i0(d4[0]), .i1(d4[1]), .i2(d4[2]), .i3(d4[3]), .i4(d4[4]),
    .i5(d4[5]), .i6(d4[6]), .i7(d4[7]), .i8(d4[8]),
    .mux_out(o4), .sel_invalid(v4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed expectations for the walk over legal codes.
  logic [0:0] exp1 [0:8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [7:0] exp8 [0:8] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
  logic [3:0] exp4 [0:8] = '{4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB};

  initial begin
    rst_n  = 1'b0;
    select = 4'd0;
    for (int k = 0; k < 9; k++) begin
      d1[k] = (k == 0) ? 1'b1 : 1'b0;
      d8[k] = 8'h10 + 8'(k);
      d4[k] = 4'(k + 3);
    end

    // Reset held with live inputs while the clock runs.
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_hold_o1", o1, 0);
      check("rst_hold_o8", o8, 0);
      check("rst_hold_v8", v8, 0);
    end
    #2 rst_n = 1'b1;
    #1 check("rst_release_no_edge_o8", o8, 0);

    // Legal-code walk with the pre-edge value checked each step.
    for (int k = 0; k < 9; k++) begin
      logic [7:0] prev8;
      prev8 = (k == 0) ? 8'h00 : exp8[k-1];
      select = 4'(k);
      #2 check($sformatf("pre_edge_o8_sel%0d", k), o8, prev8);
      tick();
      check($sformatf("walk_o1_sel%0d", k), o1, exp1[k]);
      check($sformatf("walk_o8_sel%0d", k), o8, exp8[k]);
      check($sformatf("walk_o4_sel%0d", k), o4, exp4[k]);
      check($sformatf("walk_v1_sel%0d", k), v1, 0);
    end

    // Illegal codes.
    select = 4'd9;
    tick();
    check("inv9_o1", o1, 0);
    check("inv9_v1", v1, 1);
    check("inv9_o8", o8, 0);
    check("inv9_o4", o4, 4'hF);
    check("inv9_v4", v4, 1);
    select = 4'd15;
    tick();
    check("inv15_o8", o8, 0);
    check("inv15_v8", v8, 1);
    select = 4'd12;
    tick();
    check("inv12_o4", o4, 4'hF);
    check("inv12_v4", v4, 1);

    // Back to a legal code.
    d1[2]  = 1'b1;
    select = 4'd2;
    tick();
    check("ret2_o1", o1, 1);
    check("ret2_v1", v1, 0);
    check("ret2_o8", o8, 8'h12);

    // Data change under a fixed select.
    select = 4'd5;
    d8[5]  = 8'hAA;
    tick();
    check("fix5_aa", o8, 8'hAA);
    #2 d8[5] = 8'h55;
    #1 check("fix5_hold_before_edge", o8, 8'hAA);
    tick();
    check("fix5_55", o8, 8'h55);
    d8[4] = 8'hFF;
    tick();
    check("fix5_i4_ignored", o8, 8'h55);

    // Asynchronous reset mid-cycle while the flag is set.
    select = 4'd13;
    tick();
    check("pre_arst_v8", v8, 1);
    check("pre_arst_o4", o4, 4'hF);
    #2 rst_n = 1'b0;
    #1;
    check("arst_o4", o4, 0);
    check("arst_v4", v4, 0);
    check("arst_v8", v8, 0);
    select = 4'd0;
    tick();
    check("arst_hold_o1", o1, 0);
    #1 rst_n = 1'b1;
    #1 check("arst_release_no_edge_o1", o1, 0);
    tick();
    check("post_arst_o1", o1, 1);
    check("post_arst_o8", o8, 8'h10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
